// File: rtl/cpu_pkg.sv
// Shared types, widths and instruction-field helpers for the bus-processor control unit.
// Instruction word: [9:6] opcode, [5:4] RX, [3:2] RY, [1:0] unused.
package cpu_pkg;

    localparam int DATA_W = 10;
    localparam int OP_W   = 4;
    localparam int REG_AW = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 4'd0,
        OP_COPY = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INV  = 4'd4,
        OP_NOP  = 4'd5
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_INV  = 2'd2,
        ALU_RSVD = 2'd3
    } alu_op_t;

    function automatic logic [OP_W-1:0] ir_op(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: OP_W];
    endfunction

    function automatic logic [REG_AW-1:0] ir_rx(input logic [DATA_W-1:0] w);
        return w[5:4];
    endfunction

    function automatic logic [REG_AW-1:0] ir_ry(input logic [DATA_W-1:0] w);
        return w[3:2];
    endfunction

endpackage

// File: rtl/step_counter.sv
// Timestep counter: async reset, synchronous clear on the final step, count enable.
// Latency: count updates on the clock edge; no backpressure.
module step_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: latches an instruction in T0, decodes (TIME, IR) into bus/ALU enables.
// Latency: 1 cycle from accepted EXEC to first execute step; outputs combinational from state.
// Backpressure: none; EXEC is only honoured in T0. Optional ERR output under CTRL_ERR_EN.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXEC,
    input  logic [DATA_W-1:0] INSTR,
    output logic              IR_LD,
    output logic              EXT_OUT,
    output logic              ROUT_EN,
    output logic [REG_AW-1:0] RSEL_OUT,
    output logic              RIN_EN,
    output logic [REG_AW-1:0] RSEL_IN,
    output logic              A_LD,
    output logic              G_LD,
    output logic              G_OUT,
    output logic [1:0]        ALU_OP,
    output logic [1:0]        TIME,
`ifdef CTRL_ERR_EN
    output logic              ERR,
`endif
    output logic              DONE
);

    logic [DATA_W-1:0] ir;
    logic [1:0]        t;
    logic              accept;
    logic              unused_bits;

    assign accept      = (t == 2'd0) && EXEC;
    assign TIME        = t;
    assign unused_bits = ^ir[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir <= '0;
        end else if (accept) begin
            ir <= INSTR;
        end
    end

    step_counter u_step (
        .clk (CLK),
        .rst (RST),
        .clr (DONE),
        .en  (accept || (t != 2'd0)),
        .cnt (t)
    );

    always_comb begin
        IR_LD    = 1'b0;
        EXT_OUT  = 1'b0;
        ROUT_EN  = 1'b0;
        RSEL_OUT = '0;
        RIN_EN   = 1'b0;
        RSEL_IN  = '0;
        A_LD     = 1'b0;
        G_LD     = 1'b0;
        G_OUT    = 1'b0;
        ALU_OP   = ALU_ADD;
        DONE     = 1'b0;
        case (t)
            2'd0: IR_LD = EXEC && !RST;
            2'd1: begin
                case (ir_op(ir))
                    OP_LOAD: begin
                        EXT_OUT = 1'b1;
                        RIN_EN  = 1'b1;
                        RSEL_IN = ir_rx(ir);
                        DONE    = 1'b1;
                    end
                    OP_COPY: begin
                        ROUT_EN  = 1'b1;
                        RSEL_OUT = ir_ry(ir);
                        RIN_EN   = 1'b1;
                        RSEL_IN  = ir_rx(ir);
                        DONE     = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_INV: begin
                        ROUT_EN  = 1'b1;
                        RSEL_OUT = ir_rx(ir);
                        A_LD     = 1'b1;
                    end
                    default: DONE = 1'b1;
                endcase
            end
            2'd2: begin
                case (ir_op(ir))
                    OP_ADD, OP_SUB: begin
                        ROUT_EN  = 1'b1;
                        RSEL_OUT = ir_ry(ir);
                        ALU_OP   = (ir_op(ir) == OP_SUB) ? ALU_SUB : ALU_ADD;
                        G_LD     = 1'b1;
                    end
                    OP_INV: begin
                        ALU_OP = ALU_INV;
                        G_LD   = 1'b1;
                    end
                    default: DONE = 1'b1;
                endcase
            end
            default: begin
                // Only ALU ops reach T3; anything else just returns to T0.
                DONE = 1'b1;
                if (ir_op(ir) == OP_ADD || ir_op(ir) == OP_SUB || ir_op(ir) == OP_INV) begin
                    G_OUT   = 1'b1;
                    RIN_EN  = 1'b1;
                    RSEL_IN = ir_rx(ir);
                end
            end
        endcase
    end

`ifdef CTRL_ERR_EN
    logic err_q;
    logic undef_t1;

    assign undef_t1 = (t == 2'd1) && (ir_op(ir) > OP_NOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (undef_t1) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q || undef_t1;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: queue-based step model checked every cycle plus directed literals.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EXEC;
    logic [9:0] INSTR;
    logic       IR_LD, EXT_OUT, ROUT_EN, RIN_EN, A_LD, G_LD, G_OUT, DONE;
    logic [1:0] RSEL_OUT, RSEL_IN, ALU_OP, TIME;
`ifdef CTRL_ERR_EN
    logic       ERR;
`endif

    cpu_controller dut (
        .CLK      (CLK),
        .RST      (RST),
        .EXEC     (EXEC),
        .INSTR    (INSTR),
        .IR_LD    (IR_LD),
        .EXT_OUT  (EXT_OUT),
        .ROUT_EN  (ROUT_EN),
        .RSEL_OUT (RSEL_OUT),
        .RIN_EN   (RIN_EN),
        .RSEL_IN  (RSEL_IN),
        .A_LD     (A_LD),
        .G_LD     (G_LD),
        .G_OUT    (G_OUT),
        .ALU_OP   (ALU_OP),
        .TIME     (TIME),
`ifdef CTRL_ERR_EN
        .ERR      (ERR),
`endif
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ir_ld;
        logic       ext;
        logic       rout;
        logic [1:0] rsel_out;
        logic       rin;
        logic [1:0] rsel_in;
        logic       a_ld;
        logic       g_ld;
        logic       g_out;
        logic [1:0] alu;
        logic [1:0] tm;
        logic       done;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected control sequence of one instruction, one entry per execute step.
    task automatic push_instr(input logic [9:0] w);
        ctl_t       v;
        logic [3:0] op;
        logic [1:0] rx, ry;
        op = w[9:6];
        rx = w[5:4];
        ry = w[3:2];
        if (op == 4'd0) begin
            v = '0; v.tm = 2'd1; v.ext = 1'b1; v.rin = 1'b1; v.rsel_in = rx; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (op == 4'd1) begin
            v = '0; v.tm = 2'd1; v.rout = 1'b1; v.rsel_out = ry;
            v.rin = 1'b1; v.rsel_in = rx; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (op >= 4'd2 && op <= 4'd4) begin
            v = '0; v.tm = 2'd1; v.rout = 1'b1; v.rsel_out = rx; v.a_ld = 1'b1;
            exp_q.push_back(v);
            v = '0; v.tm = 2'd2; v.g_ld = 1'b1;
            if (op == 4'd4) v.alu = 2'd2;
            else begin v.rout = 1'b1; v.rsel_out = ry; v.alu = (op == 4'd3) ? 2'd1 : 2'd0; end
            exp_q.push_back(v);
            v = '0; v.tm = 2'd3; v.g_out = 1'b1; v.rin = 1'b1; v.rsel_in = rx; v.done = 1'b1;
            exp_q.push_back(v);
        end else begin
            v = '0; v.tm = 2'd1; v.done = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) exp_q.delete();
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (EXEC) push_instr(INSTR);
    end

    always @(negedge CLK) begin
        ctl_t act, req;
        act = {IR_LD, EXT_OUT, ROUT_EN, RSEL_OUT, RIN_EN, RSEL_IN,
               A_LD, G_LD, G_OUT, ALU_OP, TIME, DONE};
        if (exp_q.size() != 0) req = exp_q[0];
        else begin
            req = '0;
            req.ir_ld = EXEC && !RST;
        end
        chk("cycle_ctl", 32'(act), 32'(req));
        chk("bus_one_driver", 32'(int'(EXT_OUT) + int'(ROUT_EN) + int'(G_OUT) <= 1), 32'd1);
    end

    task automatic cyc(input logic e, input logic [9:0] w);
        EXEC  = e;
        INSTR = w;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        RST = 1'b1; EXEC = 1'b1; INSTR = 10'b0000_01_0000;
        #12;
        chk("reset_time", 32'(TIME), 32'd0);
        chk("reset_ir_ld", 32'(IR_LD), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        @(posedge CLK); #2;
        RST = 1'b0; EXEC = 1'b0; INSTR = '0;

        // LOAD R1
        cyc(1'b1, 10'b0000_01_0000);
        chk("load_time", 32'(TIME), 32'd1);
        chk("load_ext", 32'(EXT_OUT), 32'd1);
        chk("load_rin", 32'(RIN_EN), 32'd1);
        chk("load_rsel_in", 32'(RSEL_IN), 32'd1);
        chk("load_done", 32'(DONE), 32'd1);
        cyc(1'b0, 10'd0);
        chk("load_back_t0", 32'(TIME), 32'd0);

        // ADD R2,R3
        cyc(1'b1, 10'b0010_10_11_00);
        chk("add_t1_rsel_out", 32'(RSEL_OUT), 32'd2);
        chk("add_t1_a_ld", 32'(A_LD), 32'd1);
        cyc(1'b0, 10'd0);
        chk("add_t2_rsel_out", 32'(RSEL_OUT), 32'd3);
        chk("add_t2_alu", 32'(ALU_OP), 32'd0);
        chk("add_t2_g_ld", 32'(G_LD), 32'd1);
        cyc(1'b0, 10'd0);
        chk("add_t3_g_out", 32'(G_OUT), 32'd1);
        chk("add_t3_rsel_in", 32'(RSEL_IN), 32'd2);
        chk("add_t3_done", 32'(DONE), 32'd1);
        cyc(1'b0, 10'd0);
        chk("add_back_t0", 32'(TIME), 32'd0);

        // Reset in the middle of ADD R1,R2 at T2
        cyc(1'b1, 10'b0010_01_10_00);
        cyc(1'b0, 10'd0);
        chk("abort_pre_t2", 32'(TIME), 32'd2);
        #1 RST = 1'b1;
        #1;
        chk("abort_time", 32'(TIME), 32'd0);
        chk("abort_rin", 32'(RIN_EN), 32'd0);
        chk("abort_g_ld", 32'(G_LD), 32'd0);
        @(posedge CLK); #2;
        chk("abort_hold_rin", 32'(RIN_EN), 32'd0);
        RST = 1'b0;

        // EXEC held: SUB R0,R1 then COPY R3,R2 with INSTR toggling mid-instruction
        cyc(1'b1, 10'b0011_00_01_00);
        chk("sub_t1_rsel_out", 32'(RSEL_OUT), 32'd0);
        cyc(1'b1, 10'b0000_01_01_00);
        chk("sub_t2_rsel_out", 32'(RSEL_OUT), 32'd1);
        chk("sub_t2_alu", 32'(ALU_OP), 32'd1);
        cyc(1'b1, 10'b0100_11_11_11);
        chk("sub_t3_rsel_in", 32'(RSEL_IN), 32'd0);
        chk("sub_t3_done", 32'(DONE), 32'd1);
        cyc(1'b1, 10'b1111_10_10_10);
        chk("b2b_t0_time", 32'(TIME), 32'd0);
        chk("b2b_t0_ir_ld", 32'(IR_LD), 32'd1);
        cyc(1'b1, 10'b0001_11_10_00);
        chk("copy_rout", 32'(ROUT_EN), 32'd1);
        chk("copy_rsel_out", 32'(RSEL_OUT), 32'd2);
        chk("copy_rsel_in", 32'(RSEL_IN), 32'd3);
        chk("copy_done", 32'(DONE), 32'd1);
        cyc(1'b0, 10'd0);

        // Undefined opcode
        cyc(1'b1, 10'b1111_11_11_00);
        chk("undef_time", 32'(TIME), 32'd1);
        chk("undef_done", 32'(DONE), 32'd1);
        chk("undef_enables", 32'({EXT_OUT, ROUT_EN, RIN_EN, A_LD, G_LD, G_OUT}), 32'd0);
`ifdef CTRL_ERR_EN
        chk("undef_err_t1", 32'(ERR), 32'd1);
`endif
        cyc(1'b0, 10'd0);
`ifdef CTRL_ERR_EN
        chk("undef_err_sticky", 32'(ERR), 32'd1);
`endif
        cyc(1'b1, 10'b0101_00_00_00);
        chk("nop_done", 32'(DONE), 32'd1);
`ifdef CTRL_ERR_EN
        chk("err_cleared", 32'(ERR), 32'd0);
`endif
        cyc(1'b0, 10'd0);

        // Random opcodes with random EXEC during execute steps
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 10'($urandom));
            k = 0;
            while (exp_q.size() != 0 && k < 10) begin
                cyc(1'($urandom_range(0, 1)), 10'($urandom));
                k++;
            end
            chk("rand_back_to_t0", 32'(k < 10), 32'd1);
            if (k >= 10) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
